// File: rtl/inst_mem_pkg.sv
// -----------------------------------------------------------------------------
// inst_mem_pkg
// Shared types and constants for the instruction memory pipeline.
//   state_t       : loader/fetch mode (RUN serves fetches, LOAD accepts bytes)
//   MAX_LATENCY   : deepest supported fetch response latency
//   byte_lane()   : maps the n-th byte of a word to its byte lane
// -----------------------------------------------------------------------------
package inst_mem_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    LOAD = 1'b1
  } state_t;

  localparam int MAX_LATENCY = 4;

  // Byte lane (0 = bits 7:0) receiving the idx-th byte of a word.
  function automatic logic [1:0] byte_lane(input logic [1:0] idx, input logic msb_first);
    return msb_first ? (2'd3 - idx) : idx;
  endfunction

endpackage

// File: rtl/inst_byte_packer.sv
// -----------------------------------------------------------------------------
// inst_byte_packer
// Assembles a serial byte stream into 32-bit words for the program loader.
// Ports:
//   clock, reset    : clock and asynchronous active-high reset
//   clear_i         : discard any partial word, restart at byte 0
//   byte_valid_i    : byte_i is valid this cycle
//   byte_i          : program byte
//   flush_i         : emit the partial word (zero padded) if any bytes pending
//   word_o          : assembled word, including the byte offered this cycle
//   word_valid_o    : word_o must be written this cycle
// The word/valid outputs are combinational so the write lands on the same edge
// that accepts the completing byte.
// -----------------------------------------------------------------------------
module inst_byte_packer
  import inst_mem_pkg::*;
#(
  parameter bit LOAD_MSB_FIRST = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        clear_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  input  logic        flush_i,
  output logic [31:0] word_o,
  output logic        word_valid_o
);

  logic [31:0] acc_q, acc_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [1:0]  lane;

  always_comb begin
    lane = byte_lane(cnt_q, LOAD_MSB_FIRST);

    // Bytes land directly in their final lane; lanes not yet written stay zero,
    // which gives the zero padding of a flushed partial word for free.
    word_o = acc_q;
    if (byte_valid_i) begin
      word_o[{lane, 3'b000} +: 8] = byte_i;
    end

    // A byte arriving together with flush is merged first, then flushed.
    word_valid_o = (byte_valid_i && (cnt_q == 2'd3)) ||
                   (flush_i && (byte_valid_i || (cnt_q != 2'd0)));

    acc_d = acc_q;
    cnt_d = cnt_q;
    if (clear_i || word_valid_o) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (byte_valid_i) begin
      acc_d = word_o;
      cnt_d = cnt_q + 2'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/inst_mem_pipe.sv
// -----------------------------------------------------------------------------
// inst_mem_pipe
// Run-time loadable instruction memory with a pipelined valid/ready fetch port.
// Ports:
//   clock, reset       : clock and asynchronous active-high reset
//   req_valid/req_addr : fetch request (byte address); req_ready accepts it
//   rsp_valid/rsp_data : one response per accepted request, LATENCY cycles later
//   rsp_err            : request address was not word aligned (rsp_data = 0)
//   load_start         : enter LOAD (or restart a load), pointer back to 0
//   load_valid/byte    : program byte stream, used only in LOAD
//   load_end           : flush a partial word and return to RUN
//   loading            : high while in LOAD
//   load_words         : words written since the last load_start
//   load_ovf           : sticky, a completed word did not fit in the memory
// -----------------------------------------------------------------------------
module inst_mem_pipe
  import inst_mem_pkg::*;
#(
  parameter int ADDR_BITS      = 10,
  parameter int LATENCY        = 1,
  parameter bit LOAD_MSB_FIRST = 1'b1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 req_valid,
  input  logic [ADDR_BITS-1:0] req_addr,
  output logic                 req_ready,
  output logic                 rsp_valid,
  output logic [31:0]          rsp_data,
  output logic                 rsp_err,
  input  logic                 load_start,
  input  logic                 load_valid,
  input  logic [7:0]           load_byte,
  input  logic                 load_end,
  output logic                 loading,
  output logic [ADDR_BITS-2:0] load_words,
  output logic                 load_ovf
);

  localparam int WBITS = ADDR_BITS - 2;   // word index width
  localparam int PBITS = ADDR_BITS - 1;   // pointer must also represent DEPTH
  localparam int DEPTH = 1 << WBITS;
  localparam int LAT   = (LATENCY < 1) ? 1 :
                         (LATENCY > MAX_LATENCY) ? MAX_LATENCY : LATENCY;

  // ---------------------------------------------------------------------------
  // Loader FSM
  // ---------------------------------------------------------------------------
  state_t           state_q;
  logic [PBITS-1:0] ptr_q;
  logic             ovf_q;

  logic        in_load;
  logic        pk_clear, pk_valid, pk_flush;
  logic [31:0] pk_word;
  logic        pk_word_valid;
  logic        room;
  logic        mem_we;

  assign in_load = (state_q == LOAD);

  // load_start has priority: a byte or end pulse in the same cycle is dropped.
  assign pk_clear = load_start;
  assign pk_valid = in_load & load_valid & ~load_start;
  assign pk_flush = in_load & load_end & ~load_start;

  // The pointer never passes DEPTH, so its top bit alone flags "memory full".
  assign room   = ~ptr_q[PBITS-1];
  assign mem_we = pk_word_valid & room;

  inst_byte_packer #(
    .LOAD_MSB_FIRST(LOAD_MSB_FIRST)
  ) u_packer (
    .clock        (clock),
    .reset        (reset),
    .clear_i      (pk_clear),
    .byte_valid_i (pk_valid),
    .byte_i       (load_byte),
    .flush_i      (pk_flush),
    .word_o       (pk_word),
    .word_valid_o (pk_word_valid)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      ptr_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      unique case (state_q)
        RUN: begin
          if (load_start) begin
            state_q <= LOAD;
            ptr_q   <= '0;
            ovf_q   <= 1'b0;
          end
        end
        LOAD: begin
          if (load_start) begin
            ptr_q <= '0;
            ovf_q <= 1'b0;
          end else begin
            if (pk_word_valid) begin
              if (room) begin
                ptr_q <= ptr_q + PBITS'(1);
              end else begin
                ovf_q <= 1'b1;
              end
            end
            if (load_end) begin
              state_q <= RUN;
            end
          end
        end
        default: state_q <= RUN;
      endcase
    end
  end

  assign loading    = in_load;
  assign load_words = ptr_q;
  assign load_ovf   = ovf_q;

  // ---------------------------------------------------------------------------
  // Memory array: one write port (loader), one registered read port (fetch).
  // Not reset, so contents survive a reset.
  // ---------------------------------------------------------------------------
  logic [31:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem[ptr_q[WBITS-1:0]] <= pk_word;
    end
  end

  // ---------------------------------------------------------------------------
  // Fetch pipeline
  // ---------------------------------------------------------------------------
  logic             accept;
  logic             misaligned;
  logic [WBITS-1:0] raddr;
  logic [LAT-1:0]   valid_q, valid_d;
  logic [LAT-1:0]   err_q, err_d;
  logic [LAT-1:0][31:0] data_q;

  assign req_ready  = (state_q == RUN) & ~reset;
  assign accept     = req_valid & req_ready;
  assign misaligned = (req_addr[1:0] != 2'b00);
  assign raddr      = req_addr[ADDR_BITS-1:2];

  // Shift a new flag in at stage 0; the cast drops the stage leaving the end.
  assign valid_d = LAT'({valid_q, accept});
  assign err_d   = LAT'({err_q, accept & misaligned});

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      err_q   <= '0;
    end else begin
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  // Stage 0 is the memory read register; data is captured at accept time, so
  // responses already in flight are unaffected by a load that starts later.
  always_ff @(posedge clock) begin
    if (accept) begin
      data_q[0] <= mem[raddr];
    end
  end

  for (genvar gi = 1; gi < LAT; gi++) begin : g_data_stage
    always_ff @(posedge clock) begin
      data_q[gi] <= data_q[gi-1];
    end
  end

  assign rsp_valid = valid_q[LAT-1];
  assign rsp_err   = err_q[LAT-1];
  // Data is forced to zero outside a good response (idle, reset, misaligned).
  assign rsp_data  = (rsp_valid & ~rsp_err) ? data_q[LAT-1] : 32'h0;

endmodule

// File: tb/tb_inst_mem_pipe.sv
// Three instances share all stimulus:
//   0: ADDR_BITS=10, LATENCY=3, MSB first
//   1: ADDR_BITS=10, LATENCY=1, LSB first
//   2: ADDR_BITS=4 (depth 4), LATENCY=2, MSB first
// A request driven after edge N is accepted at edge N+1 and its response is
// visible in cycle N+LATENCY (sampled on the falling edge).
module tb_inst_mem_pipe;

  typedef logic [7:0] bq_t [$];
  typedef struct {
    int          due;
    logic [31:0] d;
    logic        e;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       req_valid = 1'b0;
  logic [9:0] req_addr = '0;
  logic       load_start = 1'b0;
  logic       load_valid = 1'b0;
  logic [7:0] load_byte = '0;
  logic       load_end = 1'b0;

  logic        rdy [3];
  logic        rv  [3];
  logic [31:0] rd  [3];
  logic        re  [3];
  logic        ld  [3];
  logic        ovf [3];
  logic [8:0]  lw_a, lw_b;
  logic [2:0]  lw_c;
  logic [8:0]  lw  [3];

  assign lw[0] = lw_a;
  assign lw[1] = lw_b;
  assign lw[2] = {6'b0, lw_c};

  int lat_t [3] = '{3, 1, 2};
  bit msb_t [3] = '{1'b1, 1'b0, 1'b1};
  int dep_t [3] = '{256, 256, 4};

  logic [31:0] mdl [3][256];
  int          expw [3];
  int          expov [3];
  exp_t        sbq [3][$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  inst_mem_pipe #(.ADDR_BITS(10), .LATENCY(3), .LOAD_MSB_FIRST(1'b1)) u_a (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(rdy[0]), .rsp_valid(rv[0]), .rsp_data(rd[0]), .rsp_err(re[0]),
    .load_start(load_start), .load_valid(load_valid), .load_byte(load_byte),
    .load_end(load_end), .loading(ld[0]), .load_words(lw_a), .load_ovf(ovf[0]));

  inst_mem_pipe #(.ADDR_BITS(10), .LATENCY(1), .LOAD_MSB_FIRST(1'b0)) u_b (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(rdy[1]), .rsp_valid(rv[1]), .rsp_data(rd[1]), .rsp_err(re[1]),
    .load_start(load_start), .load_valid(load_valid), .load_byte(load_byte),
    .load_end(load_end), .loading(ld[1]), .load_words(lw_b), .load_ovf(ovf[1]));

  inst_mem_pipe #(.ADDR_BITS(4), .LATENCY(2), .LOAD_MSB_FIRST(1'b1)) u_c (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_addr(req_addr[3:0]),
    .req_ready(rdy[2]), .rsp_valid(rv[2]), .rsp_data(rd[2]), .rsp_err(re[2]),
    .load_start(load_start), .load_valid(load_valid), .load_byte(load_byte),
    .load_end(load_end), .loading(ld[2]), .load_words(lw_c), .load_ovf(ovf[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every falling edge, each instance must show rsp_valid exactly
  // when its oldest expectation is due, with the expected data/err.
  always @(negedge clock) begin
    exp_t e;
    bit   exp_v;
    for (int i = 0; i < 3; i++) begin
      exp_v = (sbq[i].size() > 0) && (sbq[i][0].due == cyc);
      chk($sformatf("rsp_valid[%0d]@%0d", i, cyc), 32'(rv[i]), 32'(exp_v));
      if (exp_v) begin
        e = sbq[i].pop_front();
        chk($sformatf("rsp_data[%0d]@%0d", i, cyc), rd[i], e.d);
        chk($sformatf("rsp_err[%0d]@%0d", i, cyc), 32'(re[i]), 32'(e.e));
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic fetch(input logic [9:0] a);
    exp_t e;
    int   widx;
    req_valid = 1'b1;
    req_addr  = a;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("req_ready[%0d]", i), 32'(rdy[i]), 32'd1);
      widx  = (i == 2) ? int'(a[3:2]) : int'(a[9:2]);
      e.due = cyc + lat_t[i];
      e.e   = (a[1:0] != 2'b00);
      e.d   = e.e ? 32'h0 : mdl[i][widx];
      sbq[i].push_back(e);
    end
    $display("fetch addr=0x%03h cycle=%0d", a, cyc + 1);
    step();
    req_valid = 1'b0;
  endtask

  task automatic drain();
    repeat (6) step();
  endtask

  task automatic start_pulse();
    load_start = 1'b1;
    step();
    load_start = 1'b0;
  endtask

  task automatic push_byte(input logic [7:0] b, input bit with_end);
    load_valid = 1'b1;
    load_byte  = b;
    load_end   = with_end;
    step();
    load_valid = 1'b0;
    load_end   = 1'b0;
  endtask

  task automatic end_pulse();
    load_end = 1'b1;
    step();
    load_end = 1'b0;
  endtask

  // Reference packing: byte j of word k goes to lane 3-j (MSB first) or lane j.
  task automatic model_load(input bq_t b, input bit flush, output int nw);
    logic [31:0] w;
    int          idx, lane;
    nw = b.size() / 4 + ((flush && (b.size() % 4 != 0)) ? 1 : 0);
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < nw; k++) begin
        w = '0;
        for (int j = 0; j < 4; j++) begin
          idx = 4 * k + j;
          lane = msb_t[i] ? 3 - j : j;
          if (idx < b.size()) w[lane*8 +: 8] = b[idx];
        end
        if (k < dep_t[i]) mdl[i][k] = w;
      end
      expw[i]  = (nw < dep_t[i]) ? nw : dep_t[i];
      expov[i] = (nw > dep_t[i]) ? 1 : 0;
    end
  endtask

  task automatic check_status(input string tag);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s loading[%0d]", tag, i), 32'(ld[i]), 32'd0);
      chk($sformatf("%s load_words[%0d]", tag, i), 32'(lw[i]), 32'(expw[i]));
      chk($sformatf("%s load_ovf[%0d]", tag, i), 32'(ovf[i]), 32'(expov[i]));
    end
    $display("%s load_words=%0d/%0d/%0d ovf=%0d/%0d/%0d", tag, lw[0], lw[1], lw[2],
             ovf[0], ovf[1], ovf[2]);
  endtask

  task automatic do_load(input string tag, input bq_t b, input bit end_with_last);
    int nw;
    start_pulse();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s loading_on[%0d]", tag, i), 32'(ld[i]), 32'd1);
      chk($sformatf("%s ready_off[%0d]", tag, i), 32'(rdy[i]), 32'd0);
    end
    for (int k = 0; k < b.size(); k++) begin
      push_byte(b[k], end_with_last && (k == b.size() - 1));
    end
    if (!end_with_last) end_pulse();
    model_load(b, 1'b1, nw);
    check_status(tag);
  endtask

  initial begin
    bq_t bq;
    int  nw;

    // Reset state (checked while reset is still asserted)
    step();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst rsp_valid[%0d]", i), 32'(rv[i]), 32'd0);
      chk($sformatf("rst rsp_data[%0d]", i), rd[i], 32'd0);
      chk($sformatf("rst rsp_err[%0d]", i), 32'(re[i]), 32'd0);
      chk($sformatf("rst loading[%0d]", i), 32'(ld[i]), 32'd0);
      chk($sformatf("rst load_words[%0d]", i), 32'(lw[i]), 32'd0);
      chk($sformatf("rst load_ovf[%0d]", i), 32'(ovf[i]), 32'd0);
      chk($sformatf("rst req_ready[%0d]", i), 32'(rdy[i]), 32'd0);
    end
    $display("reset checked");
    reset = 1'b0;
    step();

    // A byte offered in RUN is ignored
    push_byte(8'h55, 1'b0);
    for (int i = 0; i < 3; i++) expw[i] = 0;
    for (int i = 0; i < 3; i++) expov[i] = 0;
    check_status("run_byte");

    // Two-word program, then back-to-back fetches
    bq = '{8'h13, 8'h05, 8'h00, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};
    do_load("prog8", bq, 1'b0);
    fetch(10'h000);
    fetch(10'h004);
    fetch(10'h000);
    drain();

    // Misaligned fetch followed by an aligned one
    fetch(10'h006);
    fetch(10'h004);
    drain();

    // Partial final word flushed by a separate load_end
    bq = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
    do_load("prog5", bq, 1'b0);
    fetch(10'h000);
    fetch(10'h004);
    drain();

    // Final byte arrives in the same cycle as load_end
    bq = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    do_load("prog6_end", bq, 1'b1);
    fetch(10'h004);
    drain();

    // 20 bytes: overflows the depth-4 instance only
    bq = {};
    for (int k = 0; k < 20; k++) bq.push_back(8'(8'h80 + k));
    do_load("prog20", bq, 1'b0);
    for (int k = 0; k < 5; k++) fetch(10'(4 * k));
    drain();

    // Fetch in flight when LOAD is entered completes with old data
    fetch(10'h000);
    bq = '{8'hC0, 8'hC1, 8'hC2, 8'hC3};
    do_load("inflight", bq, 1'b0);
    fetch(10'h000);
    drain();

    // Reset in the middle of a load
    start_pulse();
    bq = '{8'hD0, 8'hD1, 8'hD2, 8'hD3, 8'hD4, 8'hD5};
    for (int k = 0; k < 6; k++) push_byte(bq[k], 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("midload loading[%0d]", i), 32'(ld[i]), 32'd1);
      chk($sformatf("midload load_words[%0d]", i), 32'(lw[i]), 32'd1);
    end
    reset = 1'b1;
    #1;
    bq = '{8'hD0, 8'hD1, 8'hD2, 8'hD3};
    model_load(bq, 1'b0, nw);
    for (int i = 0; i < 3; i++) expw[i] = 0;
    for (int i = 0; i < 3; i++) expov[i] = 0;
    check_status("midreset");
    step();
    reset = 1'b0;
    step();
    fetch(10'h000);
    fetch(10'h004);
    drain();

    // Restart inside LOAD; load_start beats a simultaneous load_end
    start_pulse();
    push_byte(8'hE1, 1'b0);
    push_byte(8'hE2, 1'b0);
    push_byte(8'hE3, 1'b0);
    load_end = 1'b1;
    start_pulse();
    load_end = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("restart loading[%0d]", i), 32'(ld[i]), 32'd1);
      chk($sformatf("restart load_words[%0d]", i), 32'(lw[i]), 32'd0);
    end
    bq = '{8'hF1, 8'hF2, 8'hF3, 8'hF4};
    for (int k = 0; k < 4; k++) push_byte(bq[k], 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("restart words_now[%0d]", i), 32'(lw[i]), 32'd1);
    end
    end_pulse();
    model_load(bq, 1'b1, nw);
    check_status("restart");
    fetch(10'h000);
    fetch(10'h004);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/inst_mem_pipe.md
Name: inst_mem_pipe

Overview:
Parametrised successor to the single-cycle instruction ROM. Serves CPU instruction fetches through a valid/ready request port, with a configurable response latency and misaligned-fetch error reporting. Contents are written at run time through a byte-serial loader port (host or UART bridge), so no simulation-only file read is needed. Sits between the core's fetch stage and the board/host program-loading path.

Parameters:
ADDR_BITS, 10, byte-address width; depth = 2**(ADDR_BITS-2) words
LATENCY, 1, request-accept to rsp_valid cycles; legal 1..4
LOAD_MSB_FIRST, 1, 1: first loaded byte goes to q[31:24]; 0: first byte goes to q[7:0]

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous active-high reset
req_valid  in  1  fetch request
req_addr  in  ADDR_BITS  byte address
req_ready  out  1  request accepted when req_valid & req_ready
rsp_valid  out  1  response valid, one cycle per accepted request
rsp_data  out  32  instruction word
rsp_err  out  1  misaligned request (req_addr[1:0] != 0)
load_start  in  1  pulse: enter LOAD, pointer := 0
load_valid  in  1  load_byte valid this cycle
load_byte  in  8  program byte
load_end  in  1  pulse: flush partial word, return to RUN
loading  out  1  high in LOAD state
load_words  out  ADDR_BITS-1  words written since last load_start
load_ovf  out  1  sticky, set when load data exceeds depth

Behaviour:
- Reset (async): state = RUN, pipeline valids = 0, rsp_valid = 0, rsp_data = 0, rsp_err = 0, load pointer = 0, byte count = 0, load_words = 0, load_ovf = 0. Memory array is not cleared.
- FSM has two states, RUN and LOAD.
- RUN -> LOAD on load_start. LOAD -> RUN on load_end.
- load_start while already in LOAD restarts the load: pointer, byte count, load_words and load_ovf all go to 0, and the partial word is discarded.
- load_start and load_end in the same cycle: load_start wins.
- req_ready = (state == RUN) and not reset. loading = (state == LOAD).
- Fetch pipeline:
  - An accepted request reads word req_addr[ADDR_BITS-1:2].
  - rsp_valid rises exactly LATENCY cycles after the accept edge.
  - One request per cycle, fully pipelined, no response backpressure.
  - Misaligned request: rsp_err = 1, rsp_data = 0, same latency.
  - Requests already in flight when LOAD is entered still complete, with read data taken at accept time.
- Loader:
  - In LOAD, each load_valid byte shifts into a 32-bit assembly register in the order set by LOAD_MSB_FIRST.
  - On the 4th byte the word is written at the pointer, the pointer increments and load_words increments, all in the same cycle.
  - The pointer does not wrap. Once pointer == depth, further completed words are dropped and load_ovf is set.
  - load_end with 1-3 pending bytes writes the word zero-padded in the missing byte positions, then returns to RUN.
  - load_valid in RUN is ignored.
  - load_valid and load_end in the same cycle: the byte is included first, then the flush happens.
- Read-during-write: a fetch cannot coincide with a loader write, since req_ready = 0 in LOAD.
- Reset mid-load: FSM returns to RUN, the partial word is lost, and already-written words stay in memory.

Decomposition:
- Package inst_mem_pkg holds typedef state_t {RUN, LOAD} and the constant MAX_LATENCY = 4.
- One sub-module, inst_byte_packer: byte shift/assembly, byte counter, zero-pad flush. It outputs word and word_valid.
- Memory array and latency shift register stay in the top.

Test Plan:
- Reset, then load_start, then 8 bytes 13 05 00 00 93 05 10 00, then load_end (LOAD_MSB_FIRST = 1) -> load_words = 2, loading returns to 0. Fetch 0x0 gives rsp_data = 0x13050000; fetch 0x4 gives 0x93051000.
- LATENCY = 3, back-to-back fetches 0x0, 0x4, 0x0 -> rsp_valid high on cycles 3, 4, 5 after the first accept, with matching data and no gaps.
- Fetch 0x6 -> rsp_err = 1, rsp_data = 0 after LATENCY cycles. The following aligned fetch returns rsp_err = 0.
- load_start, then 5 bytes AA BB CC DD EE, then load_end -> word0 = 0xAABBCCDD, word1 = 0xEE000000, load_words = 2. Repeat with LOAD_MSB_FIRST = 0 -> word0 = 0xDDCCBBAA, word1 = 0x000000EE.
- ADDR_BITS = 4 (depth 4): load 20 bytes -> load_words = 4, load_ovf = 1, and word0 is unchanged by the 5th word.
- Assert reset mid-load after 6 bytes -> loading = 0, load_words = 0, and word0 still holds the first 4 bytes. load_start during LOAD -> pointer restarts at 0.
